// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply exponentiation controller in the Montgomery
// domain; drives one external multiplier through a start / done / out_read handshake.
module mont_exp_ctrl #(
  parameter int WIDTH     = 381,
  parameter int EXP_WIDTH = 381
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  input  logic [WIDTH-1:0]     one_mont,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_m,
  output logic                 mm_out_read,
  input  logic [WIDTH-1:0]     mm_result,
  input  logic                 mm_done,
  output logic [3:0]           dbg_state
);

  localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    SQ_SETUP = 4'd1,
    SQ_GO    = 4'd2,
    SQ_WAIT  = 4'd3,
    SQ_ACK   = 4'd4,
    MU_SETUP = 4'd5,
    MU_GO    = 4'd6,
    MU_WAIT  = 4'd7,
    MU_ACK   = 4'd8,
    NEXT     = 4'd9,
    FIN      = 4'd10
  } state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     base_r, mod_r, acc;
  logic [EXP_WIDTH-1:0] exp_r;
  logic [IW-1:0]        idx;
  logic                 ack_sent;

  // Handshake: mm_start is a one-cycle request issued only after mm_done has
  // dropped; operands are valid from SETUP until the single-cycle mm_out_read,
  // which is issued on the first ACK cycle while mm_done is high.
  always_comb begin
    state_next  = state;
    mm_start    = 1'b0;
    mm_out_read = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE:     if (start) state_next = SQ_SETUP;
      SQ_SETUP: state_next = SQ_GO;
      SQ_GO: begin
        mm_start   = 1'b1;
        state_next = SQ_WAIT;
      end
      SQ_WAIT:  if (mm_done) state_next = SQ_ACK;
      SQ_ACK: begin
        mm_out_read = !ack_sent;
        if (ack_sent && !mm_done) state_next = exp_r[idx] ? MU_SETUP : NEXT;
      end
      MU_SETUP: state_next = MU_GO;
      MU_GO: begin
        mm_start   = 1'b1;
        state_next = MU_WAIT;
      end
      MU_WAIT:  if (mm_done) state_next = MU_ACK;
      MU_ACK: begin
        mm_out_read = !ack_sent;
        if (ack_sent && !mm_done) state_next = NEXT;
      end
      NEXT:     state_next = (idx == '0) ? FIN : SQ_SETUP;
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

  // Operand registers load on the edge entering a SETUP state so they are
  // already stable for the whole SETUP cycle preceding mm_start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      ack_sent <= 1'b0;
      base_r   <= '0;
      mod_r    <= '0;
      exp_r    <= '0;
      acc      <= '0;
      idx      <= '0;
      result   <= '0;
      mm_a     <= '0;
      mm_b     <= '0;
      mm_m     <= '0;
    end else begin
      state    <= state_next;
      ack_sent <= (state == SQ_ACK) || (state == MU_ACK);
      case (state)
        IDLE: if (start) begin
          base_r <= base;
          mod_r  <= modulus;
          exp_r  <= exponent;
          acc    <= one_mont;
          idx    <= IW'(EXP_WIDTH - 1);
          mm_a   <= one_mont;
          mm_b   <= one_mont;
          mm_m   <= modulus;
        end
        SQ_WAIT, MU_WAIT: if (mm_done) acc <= mm_result;
        SQ_ACK: if (state_next == MU_SETUP) begin
          mm_a <= acc;
          mm_b <= base_r;
          mm_m <= mod_r;
        end
        NEXT: begin
          if (idx == '0) begin
            result <= acc;
          end else begin
            idx  <= idx - 1'b1;
            mm_a <= acc;
            mm_b <= acc;
            mm_m <= mod_r;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl: small 8-bit instance with a behavioural
// Montgomery core plus a full-width BLS12-381 Fermat inversion run.
module tb_mont_exp_ctrl;

  logic clk = 1'b0;
  logic resetn, core_rstn;
  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  // ---------------- small instance (WIDTH=8, EXP_WIDTH=4) ----------------
  logic       s_start;
  logic [7:0] s_base, s_modulus, s_one, s_result, s_mm_a, s_mm_b, s_mm_m, s_mm_result;
  logic [3:0] s_exponent, s_dbg;
  logic       s_done, s_busy, s_mm_start, s_mm_out_read, s_mm_done;

  mont_exp_ctrl #(.WIDTH(8), .EXP_WIDTH(4)) u_small (
    .clk(clk), .resetn(resetn), .start(s_start), .base(s_base), .exponent(s_exponent),
    .modulus(s_modulus), .one_mont(s_one), .result(s_result), .done(s_done), .busy(s_busy),
    .mm_start(s_mm_start), .mm_a(s_mm_a), .mm_b(s_mm_b), .mm_m(s_mm_m),
    .mm_out_read(s_mm_out_read), .mm_result(s_mm_result), .mm_done(s_mm_done),
    .dbg_state(s_dbg)
  );

  // ---------------- full-size instance ----------------
  logic         b_start;
  logic [380:0] b_base, b_exponent, b_modulus, b_one, b_result, b_mm_a, b_mm_b, b_mm_m, b_mm_result;
  logic [3:0]   b_dbg;
  logic         b_done, b_busy, b_mm_start, b_mm_out_read, b_mm_done;

  mont_exp_ctrl #(.WIDTH(381), .EXP_WIDTH(381)) u_big (
    .clk(clk), .resetn(resetn), .start(b_start), .base(b_base), .exponent(b_exponent),
    .modulus(b_modulus), .one_mont(b_one), .result(b_result), .done(b_done), .busy(b_busy),
    .mm_start(b_mm_start), .mm_a(b_mm_a), .mm_b(b_mm_b), .mm_m(b_mm_m),
    .mm_out_read(b_mm_out_read), .mm_result(b_mm_result), .mm_done(b_mm_done),
    .dbg_state(b_dbg)
  );

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Bit-serial reference Montgomery product a*b*2^-n mod m.
  function automatic logic [383:0] mont(input logic [383:0] a, input logic [383:0] b,
                                        input logic [383:0] m, input int n);
    logic [385:0] t;
    t = '0;
    for (int i = 0; i < n; i++) begin
      if (a[i]) t = t + {2'b00, b};
      if (t[0]) t = t + {2'b00, m};
      t = t >> 1;
    end
    if (t >= {2'b00, m}) t = t - {2'b00, m};
    return t[383:0];
  endfunction

  // ---------------- behavioural multiplier cores ----------------
  int s_cnt, s_hold, extra_hold;
  bit s_pend, s_rel;
  always @(posedge clk) begin
    if (!core_rstn) begin
      s_mm_done <= 1'b0; s_pend <= 1'b0; s_rel <= 1'b0; s_cnt <= 0; s_hold <= 0;
      s_mm_result <= '0;
    end else begin
      if (s_mm_start) begin
        s_pend      <= 1'b1;
        s_cnt       <= int'($urandom_range(3, 20));
        s_mm_result <= 8'(mont(384'(s_mm_a), 384'(s_mm_b), 384'(s_mm_m), 8));
      end else if (s_pend) begin
        if (s_cnt <= 1) begin s_mm_done <= 1'b1; s_pend <= 1'b0; end
        else s_cnt <= s_cnt - 1;
      end
      if (s_mm_done && s_mm_out_read) begin
        s_rel <= 1'b1; s_hold <= extra_hold;
      end else if (s_rel) begin
        if (s_hold == 0) begin s_mm_done <= 1'b0; s_rel <= 1'b0; end
        else s_hold <= s_hold - 1;
      end
    end
  end

  int b_cnt;
  bit b_pend;
  always @(posedge clk) begin
    if (!core_rstn) begin
      b_mm_done <= 1'b0; b_pend <= 1'b0; b_cnt <= 0; b_mm_result <= '0;
    end else begin
      if (b_mm_start) begin
        b_pend      <= 1'b1;
        b_cnt       <= int'($urandom_range(3, 20));
        b_mm_result <= 381'(mont(384'(b_mm_a), 384'(b_mm_b), 384'(b_mm_m), 381));
      end else if (b_pend) begin
        if (b_cnt <= 1) begin b_mm_done <= 1'b1; b_pend <= 1'b0; end
        else b_cnt <= b_cnt - 1;
      end
      if (b_mm_done && b_mm_out_read) b_mm_done <= 1'b0;
    end
  end

  // ---------------- monitors and protocol checker ----------------
  int          starts, dones, b_dones;
  bit          ab_equal, prev_start, prev_read, holding, ops_moved;
  logic [7:0]  done_result;
  logic [23:0] cur_ops, prev_ops, hold_ops;
  logic [380:0] b_res_cap;
  assign cur_ops = {s_mm_a, s_mm_b, s_mm_m};

  always @(negedge clk) begin
    if (!resetn) begin
      holding = 1'b0; ops_moved = 1'b0;
    end else begin
      if (s_mm_start) begin
        starts++;
        if (s_mm_a !== s_mm_b) ab_equal = 1'b0;
        check("start_one_cycle", 384'(prev_start), 384'(0));
        check("start_while_mm_done", 384'(s_mm_done), 384'(0));
        check("ops_stable_from_setup", 384'(cur_ops), 384'(prev_ops));
        hold_ops = cur_ops; holding = 1'b1; ops_moved = 1'b0;
      end else if (holding && cur_ops !== hold_ops) begin
        ops_moved = 1'b1;
      end
      if (s_mm_out_read) begin
        check("out_read_one_cycle", 384'(prev_read), 384'(0));
        check("out_read_needs_done", 384'(s_mm_done), 384'(1));
        check("out_read_with_start", 384'(s_mm_start), 384'(0));
        check("ops_held_until_read", 384'(ops_moved), 384'(0));
        holding = 1'b0;
      end
      if (s_done) begin dones++; done_result = s_result; end
      if (b_done) begin b_dones++; b_res_cap = b_result; end
    end
    prev_start = s_mm_start;
    prev_read  = s_mm_out_read;
    prev_ops   = cur_ops;
  end

  // One full exponentiation on the small instance, optional stray starts.
  task automatic run_exp(input logic [3:0] e, input logic [7:0] exp_res,
                         input int exp_starts, input bit stray);
    int cyc;
    s_exponent = e; starts = 0; dones = 0; ab_equal = 1'b1;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check("busy_after_start", 384'(s_busy), 384'(1));
    if (stray) begin
      s_start = 1'b1; s_exponent = 4'd11; s_base = 8'd7;
      @(negedge clk);
      s_start = 1'b0;
    end
    cyc = 0;
    while (dones == 0 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      s_start = (stray && cyc == 30);
    end
    s_start = 1'b0;
    repeat (3) @(negedge clk);
    check("done_within_budget", 384'(dones != 0), 384'(1));
    check("result", 384'(done_result), 384'(exp_res));
    check("result_held", 384'(s_result), 384'(exp_res));
    check("done_pulses", 384'(dones), 384'(1));
    check("mm_start_count", 384'(starts), 384'(exp_starts));
    check("busy_after_done", 384'(s_busy), 384'(0));
    s_base = 8'd5;
  endtask

  logic [383:0] p, rr, r2, x, xm;
  logic [384:0] dbl;

  initial begin
    int cyc;
    resetn = 1'b0; core_rstn = 1'b0; extra_hold = 0;
    s_start = 1'b0; s_base = 8'd5; s_exponent = 4'd0; s_modulus = 8'd13; s_one = 8'd9;
    b_start = 1'b0; b_base = '0; b_exponent = '0; b_modulus = '0; b_one = '0;
    repeat (3) @(negedge clk);
    check("rst_result", 384'(s_result), 384'(0));
    check("rst_done", 384'(s_done), 384'(0));
    check("rst_busy", 384'(s_busy), 384'(0));
    check("rst_mm_start", 384'(s_mm_start), 384'(0));
    check("rst_mm_out_read", 384'(s_mm_out_read), 384'(0));
    check("rst_mm_ops", 384'(cur_ops), 384'(0));
    resetn = 1'b1; core_rstn = 1'b1;
    @(negedge clk);

    run_exp(4'd5,  8'd2,  6, 1'b0);   // 2^5 = 6, Montgomery form 2
    run_exp(4'd11, 8'd11, 7, 1'b0);   // 2^11 = 7, Montgomery form 11
    run_exp(4'd0,  8'd9,  4, 1'b0);
    check("exp0_squares_only", 384'(ab_equal), 384'(1));
    extra_hold = 5;
    run_exp(4'd11, 8'd11, 7, 1'b0);
    run_exp(4'd5,  8'd2,  6, 1'b0);
    extra_hold = 0;
    run_exp(4'd5,  8'd2,  6, 1'b1);   // stray starts must be ignored

    // Abort from MU_WAIT via reset.
    s_exponent = 4'd11; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    cyc = 0;
    while (s_dbg !== 4'd7 && cyc < 3000) begin @(negedge clk); cyc++; end
    check("reach_mu_wait", 384'(s_dbg), 384'(7));
    resetn = 1'b0; core_rstn = 1'b0;
    @(negedge clk);
    check("abort_result", 384'(s_result), 384'(0));
    check("abort_done", 384'(s_done), 384'(0));
    check("abort_busy", 384'(s_busy), 384'(0));
    check("abort_mm_start", 384'(s_mm_start), 384'(0));
    check("abort_mm_out_read", 384'(s_mm_out_read), 384'(0));
    check("abort_mm_ops", 384'(cur_ops), 384'(0));
    check("abort_state", 384'(s_dbg), 384'(0));
    resetn = 1'b1; core_rstn = 1'b1;
    @(negedge clk);
    run_exp(4'd5, 8'd2, 6, 1'b0);

    // Full-width Fermat inversion over the BLS12-381 base field.
    p  = 384'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;
    rr = (384'd1 << 381) - p;
    r2 = rr;
    for (int i = 0; i < 381; i++) begin
      dbl = {r2, 1'b0};
      if (dbl >= {1'b0, p}) dbl = dbl - {1'b0, p};
      r2 = dbl[383:0];
    end
    x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    x[383:380] = 4'd0;
    if (x == '0) x = 384'd1;
    xm = mont(x, r2, p, 381);
    b_base = xm[380:0]; b_exponent = 381'(p - 384'd2); b_modulus = p[380:0]; b_one = rr[380:0];
    b_dones = 0;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    cyc = 0;
    while (b_dones == 0 && cyc < 60000) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    check("big_done_within_budget", 384'(b_dones != 0), 384'(1));
    check("big_inverse_times_x", mont(384'(b_res_cap), xm, p, 381), rr);
    check("big_done_pulses", 384'(b_dones), 384'(1));
    check("big_idle_after", 384'({b_busy, b_dbg}), 384'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
